// File: rtl/atomik_core_scheduler.sv
// rtl/atomik_core_scheduler.sv - two-requester round-robin scheduler feeding a single BIOS core
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   core_enable         0 blocks new grants (never aborts an in-flight transaction)
//   req_valid/req_data  per-requester request (bit0/low word = host, bit1/high word = stimulus)
//   req_ready           combinational one-hot accept, only in IDLE
//   rsp_valid/rsp_data  one-hot response valid plus shared response word
//   rsp_ready           per-requester response accept (non-owner bit ignored)
//   rsp_timeout         1 = response produced by the WAIT timeout, rsp_data = 0
//   core_data_in/valid  word and single-cycle issue strobe to the core
//   core_data_out/ready core result word and strobe (only honoured in WAIT)
//   busy                high in any state other than IDLE
//   timeout_cnt         saturating count of timeouts
//
// Optional feature macro: ATOMIK_SCHED_TIMEOUT_EN enables the WAIT timeout,
// the 16-bit wait counter and timeout_cnt. Without it WAIT waits forever.

module atomik_core_scheduler #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_enable,
    input  logic [1:0]          req_valid,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    input  logic [1:0]          rsp_ready,
    output logic                rsp_timeout,
    output logic [DATA_W-1:0]   core_data_in,
    output logic                core_data_valid,
    input  logic [DATA_W-1:0]   core_data_out,
    input  logic                core_data_ready,
    output logic                busy,
    output logic [7:0]          timeout_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_grant;
    logic              r_idx;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rsp_data;

    logic              w_accept;
    logic              w_grant_idx;
    logic              w_capture;
    logic              w_timeout_hit;

`ifdef ATOMIK_SCHED_TIMEOUT_EN
    localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wait_cnt;
    logic        r_rsp_timeout;
    logic [7:0]  r_timeout_cnt;
`else
    // Parameter is kept for interface compatibility only in this build.
    logic w_unused_timeout_param;
    assign w_unused_timeout_param = ^16'(TIMEOUT_CYCLES);
`endif

    // Next-state, grant and output decode.
    always_comb begin
        w_state_next    = r_state;
        w_accept        = 1'b0;
        w_grant_idx     = 1'b0;
        w_capture       = 1'b0;
        w_timeout_hit   = 1'b0;
        req_ready       = 2'b00;
        rsp_valid       = 2'b00;
        core_data_in    = '0;
        core_data_valid = 1'b0;
        busy            = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (core_enable && (|req_valid)) begin
                    w_accept = 1'b1;
                    // On a tie the requester that did not win last time goes next.
                    if (&req_valid) begin
                        w_grant_idx = ~r_last_grant;
                    end else begin
                        w_grant_idx = req_valid[1];
                    end
                    req_ready    = w_grant_idx ? 2'b10 : 2'b01;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_data_in    = r_data;
                core_data_valid = 1'b1;
                w_state_next    = S_WAIT;
            end
            S_WAIT: begin
                core_data_in = r_data;
                // A result arriving on the last allowed cycle beats the timeout.
                if (core_data_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end
`ifdef ATOMIK_SCHED_TIMEOUT_EN
                else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_RESP;
                end
`endif
            end
            S_RESP: begin
                rsp_valid = r_idx ? 2'b10 : 2'b01;
                if (rsp_ready[r_idx]) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_idx        <= 1'b0;
            r_data       <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_grant <= w_grant_idx;
                r_idx        <= w_grant_idx;
                r_data       <= w_grant_idx ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
            end
            if (w_capture) begin
                r_rsp_data <= core_data_out;
            end else if (w_timeout_hit) begin
                r_rsp_data <= '0;
            end
        end
    end

`ifdef ATOMIK_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= 16'd0;
            r_rsp_timeout <= 1'b0;
            r_timeout_cnt <= 8'd0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= 16'd0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_capture) begin
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_rsp_timeout <= 1'b1;
                if (r_timeout_cnt != 8'hFF) begin
                    r_timeout_cnt <= r_timeout_cnt + 8'd1;
                end
            end
        end
    end

    assign rsp_timeout = r_rsp_timeout;
    assign timeout_cnt = r_timeout_cnt;
`else
    assign rsp_timeout = 1'b0;
    assign timeout_cnt = 8'd0;
`endif

    assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_atomik_core_scheduler.sv
// tb/tb_atomik_core_scheduler.sv - self-checking bench for atomik_core_scheduler

module tb_atomik_core_scheduler;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_enable = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [2*DW-1:0] req_data = '0;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_ready = 2'b00;
    logic          rsp_timeout;
    logic [DW-1:0] core_data_in;
    logic          core_data_valid;
    logic [DW-1:0] core_data_out = '0;
    logic          core_data_ready = 1'b0;
    logic          busy;
    logic [7:0]    timeout_cnt;

    int n_vec = 0;
    int n_err = 0;

    atomik_core_scheduler #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_enable     (core_enable),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_ready       (rsp_ready),
        .rsp_timeout     (rsp_timeout),
        .core_data_in    (core_data_in),
        .core_data_valid (core_data_valid),
        .core_data_out   (core_data_out),
        .core_data_ready (core_data_ready),
        .busy            (busy),
        .timeout_cnt     (timeout_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: bench did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; core_enable = 1'b0; req_valid = 2'b00; req_data = '0;
        rsp_ready = 2'b00; core_data_ready = 1'b0; core_data_out = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if ({req_ready, rsp_valid, rsp_timeout, core_data_valid, busy} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl got=%b exp=0", {req_ready, rsp_valid, rsp_timeout, core_data_valid, busy});
        end
        n_vec++;
        if (rsp_data !== 32'h0 || core_data_in !== 32'h0 || timeout_cnt !== 8'h0) begin
            n_err++; $display("FAIL reset_data rsp_data=%h core_data_in=%h timeout_cnt=%0d exp=0", rsp_data, core_data_in, timeout_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        core_enable = 1'b1; req_valid = 2'b01; req_data = {32'h0, 32'hDEADBEEF};
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_grant req_ready=%b exp=01", req_ready); end
        step(); req_valid = 2'b00;
        n_vec++;
        if (core_data_valid !== 1'b1 || core_data_in !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL single_issue valid=%b data=%h exp=1/deadbeef", core_data_valid, core_data_in);
        end
        step();
        n_vec++;
        if (core_data_valid !== 1'b0 || core_data_in !== 32'hDEADBEEF || busy !== 1'b1) begin
            n_err++; $display("FAIL single_wait valid=%b data=%h busy=%b exp=0/deadbeef/1", core_data_valid, core_data_in, busy);
        end
        step(); step();
        n_vec++;
        if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_early_rsp rsp_valid=%b exp=00", rsp_valid); end
        core_data_ready = 1'b1; core_data_out = 32'h12345678;
        step(); core_data_ready = 1'b0; core_data_out = 32'h0;
        n_vec++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'h12345678 || rsp_timeout !== 1'b0) begin
            n_err++; $display("FAIL single_rsp valid=%b data=%h to=%b exp=01/12345678/0", rsp_valid, rsp_data, rsp_timeout);
        end
        rsp_ready = 2'b01;
        step(); rsp_ready = 2'b00;
        n_vec++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            n_err++; $display("FAIL single_done busy=%b rsp_valid=%b exp=0/00", busy, rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [31:0] exp_word;
        do_reset();
        core_enable = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        req_data = {32'hB0B00001, 32'hA0A00000};
        for (int t = 0; t < 4; t++) begin
            exp_rdy  = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_word = (t % 2 == 0) ? 32'hA0A00000 : 32'hB0B00001;
            #1;
            n_vec++;
            if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant%0d req_ready=%b exp=%b", t, req_ready, exp_rdy); end
            step();
            n_vec++;
            if (core_data_in !== exp_word) begin n_err++; $display("FAIL rr_word%0d got=%h exp=%h", t, core_data_in, exp_word); end
            step(); core_data_ready = 1'b1; core_data_out = 32'(t + 100);
            step(); core_data_ready = 1'b0;
            n_vec++;
            if (rsp_valid !== exp_rdy || rsp_data !== 32'(t + 100)) begin
                n_err++; $display("FAIL rr_rsp%0d valid=%b data=%h exp=%b/%h", t, rsp_valid, rsp_data, exp_rdy, 32'(t + 100));
            end
            step();
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
        step();
    endtask

    task automatic test_enable();
        do_reset();
        core_enable = 1'b0; req_valid = 2'b11; req_data = {32'h22222222, 32'h11111111};
        for (int k = 0; k < 20; k++) begin
            step();
            n_vec++;
            if (req_ready !== 2'b00 || busy !== 1'b0) begin
                n_err++; $display("FAIL en_blocked%0d req_ready=%b busy=%b exp=00/0", k, req_ready, busy);
            end
        end
        core_enable = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL en_grant req_ready=%b exp=01", req_ready); end
        step(); core_enable = 1'b0;
        n_vec++;
        if (core_data_valid !== 1'b1 || core_data_in !== 32'h11111111) begin
            n_err++; $display("FAIL en_issue valid=%b data=%h exp=1/11111111", core_data_valid, core_data_in);
        end
        step(); core_data_ready = 1'b1; core_data_out = 32'hCAFEF00D;
        step(); core_data_ready = 1'b0;
        n_vec++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL en_rsp valid=%b data=%h exp=01/cafef00d", rsp_valid, rsp_data);
        end
        rsp_ready = 2'b01;
        step(); rsp_ready = 2'b00;
        #1;
        n_vec++;
        if (busy !== 1'b0 || req_ready !== 2'b00) begin
            n_err++; $display("FAIL en_no_regrant busy=%b req_ready=%b exp=0/00", busy, req_ready);
        end
        step();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL en_idle busy=%b exp=0", busy); end
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        int          last;
        int          win;
        int          dly;
        int          hold;
        logic [1:0]  vm;
        logic        en;
        logic [31:0] d0, d1, wd, rd;
        do_reset();
        last = 1;
        for (int t = 0; t < 40; t++) begin
            vm = 2'($urandom_range(1, 3));
            d0 = $urandom; d1 = $urandom;
            en = ($urandom_range(0, 3) != 0);
            req_valid = vm; req_data = {d1, d0}; core_enable = en;
            if (!en) begin
                #1;
                n_vec++;
                if (req_ready !== 2'b00) begin n_err++; $display("FAIL rand_disabled%0d req_ready=%b exp=00", t, req_ready); end
                step();
                n_vec++;
                if (busy !== 1'b0) begin n_err++; $display("FAIL rand_disabled_busy%0d busy=%b exp=0", t, busy); end
                core_enable = 1'b1;
            end
            if (vm == 2'b11) win = 1 - last;
            else             win = (vm == 2'b10) ? 1 : 0;
            last = win;
            wd = (win == 1) ? d1 : d0;
            #1;
            n_vec++;
            if (req_ready !== 2'(1 << win)) begin n_err++; $display("FAIL rand_grant%0d req_ready=%b exp=%b", t, req_ready, 2'(1 << win)); end
            step();
            if ($urandom_range(0, 1) == 1) begin
                core_data_ready = 1'b1; core_data_out = $urandom;
            end
            n_vec++;
            if (core_data_valid !== 1'b1 || core_data_in !== wd || req_ready !== 2'b00) begin
                n_err++; $display("FAIL rand_issue%0d valid=%b data=%h rdy=%b exp=1/%h/00", t, core_data_valid, core_data_in, req_ready, wd);
            end
            dly = $urandom_range(0, 5);
            rd  = $urandom;
            step(); core_data_ready = 1'b0;
            for (int k = 0; k < dly; k++) begin
                n_vec++;
                if (core_data_valid !== 1'b0 || core_data_in !== wd || rsp_valid !== 2'b00) begin
                    n_err++; $display("FAIL rand_wait%0d valid=%b data=%h rsp_valid=%b exp=0/%h/00", t, core_data_valid, core_data_in, rsp_valid, wd);
                end
                step();
            end
            core_data_ready = 1'b1; core_data_out = rd;
            step(); core_data_ready = 1'b0; core_data_out = $urandom;
            hold = $urandom_range(0, 3);
            for (int k = 0; k <= hold; k++) begin
                if (k == hold) rsp_ready = 2'(1 << win);
                else           rsp_ready = ($urandom_range(0, 1) == 1) ? 2'(1 << (1 - win)) : 2'b00;
                #1;
                n_vec++;
                if (rsp_valid !== 2'(1 << win) || rsp_data !== rd || rsp_timeout !== 1'b0 || req_ready !== 2'b00) begin
                    n_err++; $display("FAIL rand_rsp%0d valid=%b data=%h to=%b rdy=%b exp=%b/%h/0/00", t, rsp_valid, rsp_data, rsp_timeout, req_ready, 2'(1 << win), rd);
                end
                step();
            end
            rsp_ready = 2'b00; req_valid = 2'b00;
            n_vec++;
            if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
                n_err++; $display("FAIL rand_done%0d busy=%b rsp_valid=%b exp=0/00", t, busy, rsp_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        core_enable = 1'b1; req_valid = 2'b01; req_data = {32'h0, 32'h0BADC0DE};
        step(); step();
        core_data_ready = 1'b1; core_data_out = 32'h5A5A1234;
        step(); core_data_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rsp_ready = (k % 3 == 1) ? 2'b10 : 2'b00;
            core_data_ready = (k % 2 == 1);
            core_data_out = $urandom;
            #1;
            n_vec++;
            if (rsp_valid !== 2'b01 || rsp_data !== 32'h5A5A1234 || req_ready !== 2'b00 || busy !== 1'b1) begin
                n_err++; $display("FAIL bp_hold%0d valid=%b data=%h rdy=%b busy=%b exp=01/5a5a1234/00/1", k, rsp_valid, rsp_data, req_ready, busy);
            end
            step();
        end
        core_data_ready = 1'b0; rsp_ready = 2'b01;
        #1;
        n_vec++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'h5A5A1234) begin
            n_err++; $display("FAIL bp_final valid=%b data=%h exp=01/5a5a1234", rsp_valid, rsp_data);
        end
        step(); rsp_ready = 2'b00; req_valid = 2'b00;
        n_vec++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            n_err++; $display("FAIL bp_idle busy=%b rsp_valid=%b exp=0/00", busy, rsp_valid);
        end
    endtask

    // Follows test_backpressure without its own reset so rsp_data starts non-zero.
    task automatic test_reset_mid();
        core_enable = 1'b1; req_valid = 2'b10; req_data = {32'h77665544, 32'h0};
        step(); req_valid = 2'b00;
        step();
        rst = 1'b1;
        step();
        #1;
        n_vec++;
        if ({req_ready, rsp_valid, rsp_timeout, core_data_valid, busy} !== 7'b0) begin
            n_err++; $display("FAIL rstmid_ctrl got=%b exp=0", {req_ready, rsp_valid, rsp_timeout, core_data_valid, busy});
        end
        n_vec++;
        if (rsp_data !== 32'h0 || core_data_in !== 32'h0 || timeout_cnt !== 8'h0) begin
            n_err++; $display("FAIL rstmid_data rsp_data=%h core_data_in=%h timeout_cnt=%0d exp=0", rsp_data, core_data_in, timeout_cnt);
        end
        rst = 1'b0; core_data_ready = 1'b1; core_data_out = 32'hFFFF0000;
        step(); core_data_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
                n_err++; $display("FAIL rstmid_late%0d rsp_valid=%b busy=%b exp=00/0", k, rsp_valid, busy);
            end
            step();
        end
    endtask

`ifdef ATOMIK_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int exp_cnt;
        do_reset();
        core_enable = 1'b1;
        exp_cnt = 0;
        for (int t = 0; t < 300; t++) begin
            req_valid = 2'b01; req_data = {32'h0, $urandom};
            step(); req_valid = 2'b00;
            step();
            for (int k = 0; k < TO - 1; k++) step();
            n_vec++;
            if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL to_early%0d rsp_valid=%b exp=00", t, rsp_valid); end
            step();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            n_vec++;
            if (rsp_valid !== 2'b01 || rsp_data !== 32'h0 || rsp_timeout !== 1'b1 || timeout_cnt !== 8'(exp_cnt)) begin
                n_err++; $display("FAIL to_rsp%0d valid=%b data=%h to=%b cnt=%0d exp=01/0/1/%0d", t, rsp_valid, rsp_data, rsp_timeout, timeout_cnt, exp_cnt);
            end
            rsp_ready = 2'b01;
            step(); rsp_ready = 2'b00;
        end
        req_valid = 2'b01; req_data = {32'h0, 32'h1};
        step(); req_valid = 2'b00;
        step();
        for (int k = 0; k < TO - 1; k++) step();
        core_data_ready = 1'b1; core_data_out = 32'h600DDA7A;
        step(); core_data_ready = 1'b0;
        n_vec++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'h600DDA7A || rsp_timeout !== 1'b0 || timeout_cnt !== 8'd255) begin
            n_err++; $display("FAIL to_priority valid=%b data=%h to=%b cnt=%0d exp=01/600dda7a/0/255", rsp_valid, rsp_data, rsp_timeout, timeout_cnt);
        end
        rsp_ready = 2'b01;
        step(); rsp_ready = 2'b00;
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        core_enable = 1'b1; req_valid = 2'b01; req_data = {32'h0, 32'h13572468};
        step(); req_valid = 2'b00;
        step();
        for (int k = 0; k < 60; k++) begin
            if (k % 10 == 9) begin
                n_vec++;
                if (busy !== 1'b1 || rsp_valid !== 2'b00 || timeout_cnt !== 8'h0) begin
                    n_err++; $display("FAIL nto_wait%0d busy=%b rsp_valid=%b cnt=%0d exp=1/00/0", k, busy, rsp_valid, timeout_cnt);
                end
            end
            step();
        end
        core_data_ready = 1'b1; core_data_out = 32'h2468ACE0;
        step(); core_data_ready = 1'b0;
        n_vec++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'h2468ACE0 || rsp_timeout !== 1'b0) begin
            n_err++; $display("FAIL nto_rsp valid=%b data=%h to=%b exp=01/2468ace0/0", rsp_valid, rsp_data, rsp_timeout);
        end
        rsp_ready = 2'b01;
        step(); rsp_ready = 2'b00;
    endtask
`endif

    initial begin
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_enable();
        test_random();
        test_backpressure();
        test_reset_mid();
`ifdef ATOMIK_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
